// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a registered grant index for the downstream 3-to-8 decoder.
// A grant is held until the owner is done, drops its request, or hits the MAX_HOLD limit.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout,
    output logic [2:0] ptr
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    localparam logic       LIMIT_EN   = (MAX_HOLD != 0);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_reg;
    logic [2:0] grant_idx_reg;
    logic       grant_valid_reg;
    logic       timeout_reg;
    logic [2:0] ptr_reg;
    logic [7:0] hold_cnt_reg;

    // Requests rotated so that bit 0 corresponds to the current search start.
    logic [7:0] rot_req;
    logic [2:0] sel_off;
    logic [2:0] sel_idx;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            logic [2:0] pos;
            assign pos         = ptr_reg + 3'(gi);
            assign rot_req[gi] = req[pos];
        end
    endgenerate

    always_comb begin
        sel_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot_req[i]) begin
                sel_off = 3'(i);
            end
        end
    end

    assign sel_idx = ptr_reg + sel_off;

    logic rel_done;
    logic rel_drop;
    logic rel_limit;
    logic rel_any;

    assign rel_done  = done;
    assign rel_drop  = ~req[grant_idx_reg];
    assign rel_limit = LIMIT_EN && (hold_cnt_reg == HOLD_LIMIT);
    assign rel_any   = rel_done | rel_drop | rel_limit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            grant_idx_reg   <= 3'd0;
            grant_valid_reg <= 1'b0;
            timeout_reg     <= 1'b0;
            ptr_reg         <= 3'd0;
            hold_cnt_reg    <= 8'd0;
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        state_reg       <= GRANT;
                        grant_idx_reg   <= sel_idx;
                        grant_valid_reg <= 1'b1;
                        hold_cnt_reg    <= 8'd1;
                    end
                end
                GRANT: begin
                    if (rel_any) begin
                        state_reg       <= IDLE;
                        grant_valid_reg <= 1'b0;
                        ptr_reg         <= grant_idx_reg + 3'd1;
                        hold_cnt_reg    <= 8'd0;
                        // A limit hit that coincides with a normal release is not a timeout.
                        timeout_reg     <= rel_limit & ~rel_done & ~rel_drop;
                    end else if (hold_cnt_reg != 8'hFF) begin
                        hold_cnt_reg <= hold_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg       <= IDLE;
                    grant_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign grant_idx   = grant_idx_reg;
    assign grant_valid = grant_valid_reg;
    assign timeout     = timeout_reg;
    assign ptr         = ptr_reg;

endmodule
